// File: rtl/count_arbiter_if.sv
// rtl/count_arbiter_if.sv - request/grant bundle between requesters, count_arbiter and the dual counter
interface count_arbiter_if;
    logic       Req0;
    logic       Req1;
    logic [3:0] Len0;
    logic [3:0] Len1;
    logic       Gnt0;
    logic       Gnt1;
    logic       Done0;
    logic       Done1;
    logic       En;
    logic       Slt;
    logic       Busy;

    modport slave (
        input  Req0, Req1, Len0, Len1,
        output Gnt0, Gnt1, Done0, Done1, En, Slt, Busy
    );

    modport master (
        output Req0, Req1, Len0, Len1,
        input  Gnt0, Gnt1, Done0, Done1, En, Slt, Busy
    );
endinterface

// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - two-requester non-preemptive burst arbiter driving a dual counter
// Option: define COUNT_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority to Req0.
module count_arbiter (
    input  logic             Clk,
    input  logic             Reset,
    count_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic       ptr_q, ptr_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       en_q, en_d;
    logic       slt_q, slt_d;
    logic       busy_q, busy_d;

    logic       win1;
    logic [3:0] len_sel;

`ifdef COUNT_ARBITER_ROUND_ROBIN_EN
    // On contention requester 1 wins only if requester 1 was not served last.
    assign win1 = bus.Req1 & (~bus.Req0 | ~ptr_q);
`else
    assign win1 = bus.Req1 & ~bus.Req0;
`endif
    assign len_sel = win1 ? bus.Len1 : bus.Len0;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        en_d    = en_q;
        slt_d   = slt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.Req0 | bus.Req1) begin
                    rem_d   = (len_sel == 4'd0) ? 5'd16 : {1'b0, len_sel};
                    state_d = win1 ? GRANT1 : GRANT0;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    en_d    = 1'b1;
                    slt_d   = win1;
                    busy_d  = 1'b1;
                    ptr_d   = win1;
                end
            end
            GRANT0, GRANT1: begin
                if (rem_q == 5'd1) begin
                    rem_d   = 5'd0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    en_d    = 1'b0;
                    slt_d   = 1'b0;
                    busy_d  = 1'b0;
                    done0_d = (state_q == GRANT0);
                    done1_d = (state_q == GRANT1);
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            rem_q   <= 5'd0;
            ptr_q   <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            en_q    <= 1'b0;
            slt_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            en_q    <= en_d;
            slt_q   <= slt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Gnt0  = gnt0_q;
    assign bus.Gnt1  = gnt1_q;
    assign bus.Done0 = done0_q;
    assign bus.Done1 = done1_q;
    assign bus.En    = en_q;
    assign bus.Slt   = slt_q;
    assign bus.Busy  = busy_q;
endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - scoreboard bench for count_arbiter
module tb_count_arbiter;
    logic Clk = 1'b0;
    logic Reset = 1'b0;

    count_arbiter_if bus ();
    count_arbiter dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct {
        int id;
        int len;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int idle_cnt = 100;
    int start_slt = 0;
    bit prev_done = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int outs();
        return {bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.En, bus.Slt, bus.Busy};
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            en_cnt    = 0;
            idle_cnt  = 100;
            prev_done = 1'b0;
        end else begin
            check_eq("one_gnt", bus.Gnt0 & bus.Gnt1, 0);
            check_eq("one_done", bus.Done0 & bus.Done1, 0);
            check_eq("busy", bus.Busy, bus.Gnt0 | bus.Gnt1);
            check_eq("en_vs_gnt", bus.En, bus.Gnt0 | bus.Gnt1);
            check_eq("slt_vs_gnt", bus.Slt, bus.Gnt1);
            check_eq("done_width", prev_done & (bus.Done0 | bus.Done1), 0);
            if (bus.En) begin
                if (en_cnt == 0) begin
                    check_eq("idle_gap", idle_cnt >= 2, 1);
                    start_slt = bus.Slt;
                end
                en_cnt++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            prev_done = bus.Done0 | bus.Done1;
            if (bus.Done0 | bus.Done1) begin
                check_eq("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("done_id", bus.Done1, e.id);
                    check_eq("burst_len", en_cnt, e.len);
                    check_eq("burst_slt", start_slt, e.id);
                end
                en_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic drive_req(input int id, input logic v);
        if (id == 0) bus.Req0 = v;
        else bus.Req1 = v;
    endtask

    task automatic drive_len(input int id, input int l);
        if (id == 0) bus.Len0 = 4'(l);
        else bus.Len1 = 4'(l);
    endtask

    task automatic push_exp(input int id, input int l);
        sb.push_back('{id: id, len: (l == 0) ? 16 : l});
    endtask

    task automatic wait_busy(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge Clk); #1;
            ok = bus.Busy;
        end
        check_eq(tag, ok, 1);
    endtask

    task automatic wait_dones(input string tag, input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk); #1;
            ok = (done_cnt >= target);
        end
        check_eq(tag, ok, 1);
    endtask

    // Request is dropped and Len scrambled right after the grant to prove the burst is latched.
    task automatic run_burst(input int id, input int l, input bit compete);
        int target;
        target = done_cnt + 1;
        drive_len(id, l);
        drive_req(id, 1'b1);
        push_exp(id, l);
        wait_busy("gnt_timeout");
        drive_req(id, 1'b0);
        drive_len(id, l ^ 4'hF);
        if (compete) begin
            drive_req(1 - id, 1'b1);
            repeat (2) @(negedge Clk);
            #1 drive_req(1 - id, 1'b0);
        end
        wait_dones("done_timeout", target);
        repeat (2) @(negedge Clk);
        #1;
    endtask

    initial begin
        int target;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        bus.Len0 = 4'd0;
        bus.Len1 = 4'd0;
        #1 check_eq("reset_outs", outs(), 0);
        repeat (2) @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk); #1;

        run_burst(0, 3, 1'b0);
        run_burst(1, 8, 1'b1);
        run_burst(0, 0, 1'b0);
        run_burst(0, 5, 1'b0);
        run_burst(1, 1, 1'b0);

        bus.Len0 = 4'd2;
        bus.Len1 = 4'd2;
`ifdef COUNT_ARBITER_ROUND_ROBIN_EN
        push_exp(0, 2); push_exp(1, 2); push_exp(0, 2); push_exp(1, 2);
`else
        push_exp(0, 2); push_exp(0, 2); push_exp(0, 2); push_exp(0, 2);
`endif
        target = done_cnt + 4;
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        wait_dones("held_timeout", target);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        repeat (3) @(negedge Clk);
        #1;

        // Abort a Len1=6 burst in its second cycle; no Done1 may follow.
        bus.Len1 = 4'd6;
        bus.Req1 = 1'b1;
        wait_busy("abort_gnt_timeout");
        bus.Req1 = 1'b0;
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1 check_eq("abort_outs", outs(), 0);
        repeat (2) @(negedge Clk);
        #1 Reset = 1'b1;
        check_eq("post_rst_outs", outs(), 0);

        target = done_cnt + 1;
        bus.Len0 = 4'd2;
        bus.Len1 = 4'd2;
        push_exp(0, 2);
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        wait_busy("post_rst_gnt_timeout");
        check_eq("post_rst_gnt0", bus.Gnt0, 1);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        wait_dones("post_rst_done_timeout", target);

        repeat (5) @(negedge Clk);
        #1 check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
